branch_unit: RTL and testbench
==============================

# branch_unit

Parametrised, clocked branch unit for the bitty processor. It owns the program counter register, captures the most recent ALU result, and resolves conditional and unconditional branches. It also implements CALL/RET through an internal return-address stack with configurable depth. It sits between instruction fetch and the ALU writeback path and supplies both the current PC and the combinational next PC to fetch.

## Interface

Parameters:
- PC_W, 8, program counter width; the target field is instruction[4 +: PC_W].
- INSTR_W, 16, instruction width; must be at least 4 + PC_W.
- DATA_W, 16, ALU result width.
- RAS_DEPTH, 4, return-stack entries; must be at least 1.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- instr_valid  in  1  instruction is accepted this cycle; the PC advances only when this is high.
- instruction  in  INSTR_W  instruction currently executing at pc.
- alu_valid  in  1  alu_result is valid; it is captured at the clock edge.
- alu_result  in  DATA_W  ALU result.
- pc  out  PC_W  registered program counter.
- next_pc  out  PC_W  combinational PC that will be loaded if the instruction is accepted.
- taken  out  1  registered; high for one cycle after an accepted instruction redirected the PC.
- ras_count  out  $clog2(RAS_DEPTH+1)  registered number of occupied stack entries.
- stack_err  out  1  sticky overflow/underflow flag; cleared only by reset.

## Operation

- Opcode instruction[1:0]; field instruction[3:2] is called sel; tgt = instruction[4 +: PC_W]; inc = pc + 1 modulo 2^PC_W.
- Opcode 2 (BRANCH), selected by sel:
  - sel 0: taken if last_result == 0.
  - sel 1: taken if last_result == 1.
  - sel 2: taken if last_result == 2.
  - sel 3: unconditional.
  - Taken: next_pc = tgt. Not taken: next_pc = inc.
- Opcode 3 (STACK):
  - sel 0 is CALL: push inc and set next_pc = tgt.
  - sel 1 is RET: pop and set next_pc to the popped value.
  - sel 2 and 3 are treated as non-branch.
- Opcodes 0 and 1 are non-branch: next_pc = inc.
- Comparisons zero-extend the constants to DATA_W.
- last_result:
  - Register, loaded from alu_result on any edge where alu_valid is high, independent of instr_valid.
  - Branches compare against the registered value. A same-cycle alu_valid does not affect the current branch decision; it becomes visible on the next cycle.
- CALL with ras_count == RAS_DEPTH: the jump still occurs, the push is dropped, stack contents are unchanged, and stack_err is set.
- RET with ras_count == 0: next_pc = inc, taken is 0, and stack_err is set.
- When instr_valid is low: pc, stack, ras_count and taken all hold or clear as follows. taken goes to 0. next_pc is still driven combinationally.
- A target equal to inc is still reported as taken (taken = 1).

## Timing

- Reset values:
  - pc = RESET_PC, taken = 0, ras_count = 0, stack_err = 0, last_result = 0.
  - Stack storage does not need to be reset.
- Reset asserted mid-CALL or mid-RET abandons the operation; after release, the state is exactly the reset state.
- next_pc has zero latency, combinational from pc, instruction, last_result and stack top.
- pc takes next_pc on the first rising edge at which instr_valid is high.
- taken and ras_count reflect that instruction one cycle after acceptance.
- PC wrap-around: pc = 2^PC_W - 1 with a non-branch instruction gives pc = 0. CALL at that pc pushes 0.
- Back-to-back CALL then RET on consecutive accepted cycles: the RET pops the value pushed the previous cycle.
- No pipelining inside the block; throughput is one instruction per cycle.

## Structure

- Shared package bitty_branch_pkg holds:
  - Opcode constants OP_BRANCH = 2 and OP_STACK = 3.
  - Condition codes COND_Z = 0, COND_ONE = 1, COND_TWO = 2, COND_ALWAYS = 3.
  - Stack codes STK_CALL = 0 and STK_RET = 1.
- Sub-module return_stack:
  - LIFO, parametrised by width PC_W and RAS_DEPTH.
  - Inputs push, pop and din; outputs top, count, full and empty.
  - Ignores push when full and pop when empty.
- branch_unit contains the PC register, the last_result register, next-PC muxing, the taken register and stack_err.

## Test plan

- Reset, then 3 accepted non-branch instructions -> pc = 0, 1, 2, 3; taken stays 0 throughout.
- alu_valid with result 0, then BRANCH sel 0 tgt 0x40 -> next_pc = 0x40, pc = 0x40, taken = 1 for one cycle. Repeat with result 5 -> pc = inc, taken = 0.
- alu_valid result 1 in the same cycle as BRANCH sel 1, with a prior result of 0 -> not taken. The next BRANCH sel 1 -> taken.
- At pc = 0x10: CALL 0x80, then at 0x80 CALL 0x90, then RET, RET -> pc sequence 0x80, 0x90, 0x81, 0x11; ras_count 1, 2, 1, 0; stack_err = 0.
- RAS_DEPTH = 2: three nested CALLs -> third jump taken, ras_count stays 2, stack_err = 1. Then 3 RETs -> the third RET gives pc = inc and stack_err stays 1.
- pc = 0xFF with a non-branch instruction -> pc = 0x00. Assert reset_n low asynchronously mid-sequence -> pc = RESET_PC and all flags 0 immediately.

Source files
------------

// File: rtl/bitty_branch_pkg.sv
// Shared decode constants for the bitty branch unit: opcode, branch condition
// and stack sub-operation fields of the instruction word.
package bitty_branch_pkg;

  typedef enum logic [1:0] {
    OP_ALU_A  = 2'd0,
    OP_ALU_B  = 2'd1,
    OP_BRANCH = 2'd2,
    OP_STACK  = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    COND_Z      = 2'd0,
    COND_ONE    = 2'd1,
    COND_TWO    = 2'd2,
    COND_ALWAYS = 2'd3
  } cond_e;

  typedef enum logic [1:0] {
    STK_CALL  = 2'd0,
    STK_RET   = 2'd1,
    STK_RSV_2 = 2'd2,
    STK_RSV_3 = 2'd3
  } stk_e;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; pushes when full and pops when empty are ignored,
// leaving both contents and count untouched.
module return_stack #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             push,
  input  logic                             pop,
  input  logic [PC_W-1:0]                  din,
  output logic [PC_W-1:0]                  top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   count,
  output logic                             full,
  output logic                             empty
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full   = (count_q == CNT_W'(RAS_DEPTH));
  assign empty  = (count_q == '0);
  assign wr_idx = IDX_W'(count_q);
  assign rd_idx = IDX_W'(count_q - CNT_W'(1));
  assign top    = empty ? '0 : mem_q[rd_idx];
  assign count  = count_q;

  // NOTE: storage has no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Program counter owner for bitty: resolves conditional branches against the
// last registered ALU result and handles CALL/RET through a return stack.
module branch_unit
  import bitty_branch_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             instr_valid,
  input  logic [INSTR_W-1:0]               instruction,
  input  logic                             alu_valid,
  input  logic [DATA_W-1:0]                alu_result,
  output logic [PC_W-1:0]                  pc,
  output logic [PC_W-1:0]                  next_pc,
  output logic                             taken,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             stack_err
);

  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   next_pc_d;
  logic [PC_W-1:0]   inc;
  logic [PC_W-1:0]   tgt;
  logic [PC_W-1:0]   ras_top;
  logic [DATA_W-1:0] last_result_q;
  logic              taken_q;
  logic              stack_err_q;
  logic              redirect;
  logic              want_push;
  logic              want_pop;
  logic              err_set;
  logic              ras_full;
  logic              ras_empty;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    inc       = pc_q + PC_W'(1);
    tgt       = instruction[4 +: PC_W];
    next_pc_d = inc;
    redirect  = 1'b0;
    want_push = 1'b0;
    want_pop  = 1'b0;
    err_set   = 1'b0;
    case (opcode_e'(instruction[1:0]))
      OP_BRANCH: begin
        case (cond_e'(instruction[3:2]))
          COND_Z:      redirect = (last_result_q == DATA_W'(0));
          COND_ONE:    redirect = (last_result_q == DATA_W'(1));
          COND_TWO:    redirect = (last_result_q == DATA_W'(2));
          COND_ALWAYS: redirect = 1'b1;
        endcase
        if (redirect) next_pc_d = tgt;
      end
      OP_STACK: begin
        case (stk_e'(instruction[3:2]))
          STK_CALL: begin
            // An overflowing CALL still jumps; only the return address is lost.
            redirect  = 1'b1;
            next_pc_d = tgt;
            want_push = !ras_full;
            err_set   = ras_full;
          end
          STK_RET: begin
            if (ras_empty) begin
              err_set = 1'b1;
            end else begin
              redirect  = 1'b1;
              next_pc_d = ras_top;
              want_pop  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  return_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (instr_valid && want_push),
    .pop     (instr_valid && want_pop),
    .din     (inc),
    .top     (ras_top),
    .count   (ras_count),
    .full    (ras_full),
    .empty   (ras_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= PC_W'(RESET_PC);
      last_result_q <= '0;
      taken_q       <= 1'b0;
      stack_err_q   <= 1'b0;
    end else begin
      if (alu_valid) last_result_q <= alu_result;
      if (instr_valid) pc_q <= next_pc_d;
      taken_q <= instr_valid && redirect;
      if (instr_valid && err_set) stack_err_q <= 1'b1;
    end
  end

  assign pc        = pc_q;
  assign next_pc   = next_pc_d;
  assign taken     = taken_q;
  assign stack_err = stack_err_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit (RAS_DEPTH = 2) with immediate-assertion checks.
module tb_branch_unit;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic               alu_valid;
  logic [DATA_W-1:0]  alu_result;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    next_pc;
  logic               taken;
  logic [1:0]         ras_count;
  logic               stack_err;

  int n_cmp = 0;
  int n_err = 0;

  branch_unit #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .DATA_W    (DATA_W),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .alu_valid   (alu_valid),
    .alu_result  (alu_result),
    .pc          (pc),
    .next_pc     (next_pc),
    .taken       (taken),
    .ras_count   (ras_count),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mk(input logic [1:0] op, input logic [1:0] sel,
                                            input logic [7:0] tgt);
    return {4'h0, tgt, sel, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [INSTR_W-1:0] instr);
    instruction = instr;
    instr_valid = 1'b1;
    step();
  endtask

  task automatic alu_load(input logic [DATA_W-1:0] val);
    instr_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_result  = val;
    step();
    alu_valid   = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [7:0] e_pc, input logic e_tk,
                             input logic [1:0] e_cnt, input logic e_err);
    check({tag, ".pc"}, 32'(pc), 32'(e_pc));
    check({tag, ".taken"}, 32'(taken), 32'(e_tk));
    check({tag, ".ras_count"}, 32'(ras_count), 32'(e_cnt));
    check({tag, ".stack_err"}, 32'(stack_err), 32'(e_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instruction = '0;
    alu_valid   = 1'b0;
    alu_result  = '0;
    #12;
    check_state("reset", 8'h00, 1'b0, 2'd0, 1'b0);
    reset_n = 1'b1;

    // Straight-line code advances pc by one per accepted instruction.
    accept(mk(2'd0, 2'd0, 8'h00)); check_state("seq1", 8'h01, 1'b0, 2'd0, 1'b0);
    accept(mk(2'd1, 2'd0, 8'h00)); check_state("seq2", 8'h02, 1'b0, 2'd0, 1'b0);
    accept(mk(2'd0, 2'd0, 8'h00)); check_state("seq3", 8'h03, 1'b0, 2'd0, 1'b0);

    // Zero result: BRANCH sel 0 taken, then taken drops after one cycle.
    alu_load(16'd0);
    check("idle_hold.pc", 32'(pc), 32'h03);
    instruction = mk(2'd2, 2'd0, 8'h40); #1;
    check("bz.next_pc", 32'(next_pc), 32'h40);
    accept(mk(2'd2, 2'd0, 8'h40)); check_state("bz_taken", 8'h40, 1'b1, 2'd0, 1'b0);
    accept(mk(2'd0, 2'd0, 8'h00)); check_state("bz_after", 8'h41, 1'b0, 2'd0, 1'b0);

    // Non-zero result: same branch falls through.
    alu_load(16'd5);
    accept(mk(2'd2, 2'd0, 8'h40)); check_state("bz_not", 8'h42, 1'b0, 2'd0, 1'b0);

    // Same-cycle ALU result is not yet visible to the branch.
    alu_load(16'd0);
    alu_valid = 1'b1; alu_result = 16'd1;
    accept(mk(2'd2, 2'd1, 8'h60)); check_state("b1_same_cyc", 8'h43, 1'b0, 2'd0, 1'b0);
    alu_valid = 1'b0;
    accept(mk(2'd2, 2'd1, 8'h60)); check_state("b1_next", 8'h60, 1'b1, 2'd0, 1'b0);

    alu_load(16'd2);
    accept(mk(2'd2, 2'd2, 8'h10)); check_state("b2_taken", 8'h10, 1'b1, 2'd0, 1'b0);

    // Nested CALL/RET at full depth with back-to-back CALL then RET.
    accept(mk(2'd3, 2'd0, 8'h80)); check_state("call1", 8'h80, 1'b1, 2'd1, 1'b0);
    accept(mk(2'd3, 2'd0, 8'h90)); check_state("call2", 8'h90, 1'b1, 2'd2, 1'b0);
    instruction = mk(2'd3, 2'd1, 8'h00); #1;
    check("ret1.next_pc", 32'(next_pc), 32'h81);
    accept(mk(2'd3, 2'd1, 8'h00)); check_state("ret1", 8'h81, 1'b1, 2'd1, 1'b0);
    accept(mk(2'd3, 2'd1, 8'h00)); check_state("ret2", 8'h11, 1'b1, 2'd0, 1'b0);

    // Overflow: third CALL still jumps, push dropped, error sticks.
    accept(mk(2'd3, 2'd0, 8'h20)); check_state("ovf_call1", 8'h20, 1'b1, 2'd1, 1'b0);
    accept(mk(2'd3, 2'd0, 8'h30)); check_state("ovf_call2", 8'h30, 1'b1, 2'd2, 1'b0);
    accept(mk(2'd3, 2'd0, 8'h40)); check_state("ovf_call3", 8'h40, 1'b1, 2'd2, 1'b1);
    accept(mk(2'd3, 2'd1, 8'h00)); check_state("ovf_ret1", 8'h21, 1'b1, 2'd1, 1'b1);
    accept(mk(2'd3, 2'd1, 8'h00)); check_state("ovf_ret2", 8'h12, 1'b1, 2'd0, 1'b1);
    instruction = mk(2'd3, 2'd1, 8'h00); #1;
    check("udf.next_pc", 32'(next_pc), 32'h13);
    accept(mk(2'd3, 2'd1, 8'h00)); check_state("udf_ret3", 8'h13, 1'b0, 2'd0, 1'b1);

    // Reserved stack sub-op behaves as a plain instruction.
    accept(mk(2'd3, 2'd2, 8'h77)); check_state("stk_rsv", 8'h14, 1'b0, 2'd0, 1'b1);

    // PC wrap-around, both for sequential flow and for the CALL return address.
    accept(mk(2'd2, 2'd3, 8'hFF)); check_state("to_ff", 8'hFF, 1'b1, 2'd0, 1'b1);
    accept(mk(2'd0, 2'd0, 8'h00)); check_state("wrap", 8'h00, 1'b0, 2'd0, 1'b1);
    accept(mk(2'd2, 2'd3, 8'hFF)); check_state("to_ff2", 8'hFF, 1'b1, 2'd0, 1'b1);
    accept(mk(2'd3, 2'd0, 8'h05)); check_state("call_wrap", 8'h05, 1'b1, 2'd1, 1'b1);
    accept(mk(2'd3, 2'd1, 8'h00)); check_state("ret_wrap", 8'h00, 1'b1, 2'd0, 1'b1);

    // Asynchronous reset during an accepted CALL.
    accept(mk(2'd3, 2'd0, 8'h50)); check_state("pre_rst", 8'h50, 1'b1, 2'd1, 1'b1);
    instruction = mk(2'd3, 2'd0, 8'h60);
    #3 reset_n = 1'b0;
    #1 check_state("async_rst", 8'h00, 1'b0, 2'd0, 1'b0);
    instr_valid = 1'b0;
    #1 reset_n = 1'b1;
    step(); check_state("post_rst", 8'h00, 1'b0, 2'd0, 1'b0);
    // last_result was 2 before reset; a taken BZ proves it was cleared.
    accept(mk(2'd2, 2'd0, 8'h33)); check_state("post_rst_bz", 8'h33, 1'b1, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
